// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with parity/stop checking feeding a show-ahead receive FIFO
module uart_rx_fifo #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ser_rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun,
  input  logic                          clear_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = DATA_BITS + 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Receiver state
  logic                 sync_q1;
  logic                 sync_q2;
  logic                 rx_s;
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err;

  // FIFO state
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;

  // Push/pop decode
  logic                 push;
  logic [EW-1:0]        push_entry;
  logic                 pop;
  logic                 room;
  logic                 accept;
  logic                 drop;
  logic [PW-1:0]        rd_next;
  logic [LW-1:0]        level_next;
  logic [EW-1:0]        head_next;

  assign rx_s = sync_q2;

  // Two-flop synchronizer on the asynchronous line; resets to the idle level
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= ser_rx;
      sync_q2 <= sync_q1;
    end
  end

  // Frame FSM: mid-bit sampling via cnt, LSB-first shift, parity and stop checks
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      par_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            idx     <= '0;
            par_err <= 1'b0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            idx   <= idx + 1'b1;
            if (idx == IDX_LAST) begin
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_STOP;
            if (PARITY == 1) begin
              par_err <= ~(^shift ^ rx_s);
            end else begin
              par_err <= ^shift ^ rx_s;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= rx_s ? S_IDLE : S_WAIT_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // The entry is written on the same edge that samples the stop bit
  assign push       = (state == S_STOP) && (cnt == CNT_LAST);
  assign push_entry = {~rx_s, par_err, shift};

  // A pop frees a slot in the same cycle, so a full FIFO still accepts then
  assign pop        = rx_valid && rx_ready;
  assign room       = (fifo_level < LVL_FULL) || pop;
  assign accept     = push && room;
  assign drop       = push && !room;
  assign rd_next    = rd_ptr + PW'(pop);
  assign level_next = fifo_level + LW'(accept) - LW'(pop);

  // Next head: a fresh push becomes the head when it lands in the slot rd_next points at
  assign head_next  = (accept && (rd_next == wr_ptr)) ? push_entry : mem[rd_next];

  // Entry storage; no reset needed since only written slots are ever read
  always_ff @(posedge clk) begin
    if (resetn && accept) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers, level and registered show-ahead head; head holds while empty
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr     <= rd_next;
      fifo_level <= level_next;
      rx_valid   <= (level_next != '0);
      if (level_next != '0) begin
        rx_frame_err  <= head_next[EW-1];
        rx_parity_err <= head_next[EW-2];
        rx_data       <= head_next[DATA_BITS-1:0];
      end
    end
  end

  // Sticky overrun; a drop wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clear_err) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo with a queue-based reference model
module tb_uart_rx_fifo;

  localparam int CLK_DIV    = 16;
  localparam int DATA_BITS  = 8;
  localparam int PARITY     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  // Edges from the start-bit drive to the stop-bit sample: 2 synchronizer flops,
  // 1 idle detect, half a bit to the start centre, then start-centre to stop-centre.
  localparam int PUSH_LAT   = 3 + CLK_DIV / 2 + (DATA_BITS + 2) * CLK_DIV;
  localparam int VALID_LIM  = (21 * CLK_DIV) / 2 + 4;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 ser_rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 overrun;
  logic                 clear_err;
  logic [LW-1:0]        fifo_level;

  uart_rx_fifo #(
    .CLK_DIV   (CLK_DIV),
    .DATA_BITS (DATA_BITS),
    .PARITY    (PARITY),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ser_rx       (ser_rx),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .overrun      (overrun),
    .clear_err    (clear_err),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [9:0] ent;
  } pend_t;

  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;
  pend_t       pend[$];
  logic [9:0]  m_q[$];
  logic [9:0]  m_head = '0;
  logic        m_ovr = 1'b0;
  logic        rand_mode = 1'b0;
  int          ready_div = 2;
  int          wait_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame (start, 8 data LSB first, parity, stop) and schedules the expected entry
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb);
    pend_t p;
    @(negedge clk);
    ser_rx = 1'b0;
    p.due = edge_cnt + PUSH_LAT;
    p.ent = {~stopb, ^{d, pbit}, d};
    pend.push_back(p);
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < DATA_BITS; i++) begin
      ser_rx = d[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    ser_rx = pbit;
    repeat (CLK_DIV) @(negedge clk);
    ser_rx = stopb;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic pop_one;
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // Reference model: FIFO as a queue, updated from inputs seen at each rising edge,
  // then every DUT output compared against it
  always @(posedge clk) begin
    logic m_pop;
    logic m_push;
    logic m_acc;
    logic [9:0] ent;
    edge_cnt++;
    if (!resetn) begin
      pend.delete();
      m_q.delete();
      m_head = '0;
      m_ovr  = 1'b0;
    end else begin
      m_pop  = (m_q.size() > 0) && rx_ready;
      m_push = (pend.size() > 0) && (pend[0].due == edge_cnt);
      ent    = '0;
      if (m_push) begin
        ent = pend[0].ent;
        void'(pend.pop_front());
      end
      m_acc = m_push && ((m_q.size() < FIFO_DEPTH) || m_pop);
      if (m_pop) void'(m_q.pop_front());
      if (m_acc) m_q.push_back(ent);
      if (m_push && !m_acc) m_ovr = 1'b1;
      else if (clear_err) m_ovr = 1'b0;
      if (m_q.size() > 0) m_head = m_q[0];
    end
    #1;
    check("rx_valid", rx_valid, (m_q.size() > 0));
    check("fifo_level", fifo_level, m_q.size());
    check("overrun", overrun, m_ovr);
    check("head", {rx_frame_err, rx_parity_err, rx_data}, m_head);
  end

  // Random consumer and error-clear activity during the random phase
  always @(negedge clk) begin
    if (rand_mode) begin
      rx_ready  = ($urandom_range(0, ready_div - 1) == 0);
      clear_err = ($urandom_range(0, 199) == 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic       pb;
    logic       sb;
    ser_rx    = 1'b1;
    resetn    = 1'b0;
    rx_ready  = 1'b0;
    clear_err = 1'b0;
    idle(4);
    check("reset_valid", rx_valid, 0);
    check("reset_level", fifo_level, 0);
    check("reset_overrun", overrun, 0);
    check("reset_data", {rx_frame_err, rx_parity_err, rx_data}, 0);
    resetn = 1'b1;
    idle(20);

    // Good byte with latency bound
    fork
      send_frame(8'h55, 1'b0, 1'b1);
      begin
        wait_cyc = 0;
        @(negedge clk);
        while (!rx_valid && wait_cyc < 400) begin
          @(negedge clk);
          wait_cyc++;
        end
      end
    join
    check("latency_within_limit", (wait_cyc <= VALID_LIM), 1);
    check("x55_valid", rx_valid, 1);
    check("x55_data", rx_data, 8'h55);
    check("x55_flags", {rx_frame_err, rx_parity_err}, 2'b00);
    check("x55_level", fifo_level, 1);
    pop_one();
    idle(20);

    // Wrong parity
    send_frame(8'hA3, 1'b1, 1'b1);
    idle(4);
    check("xa3_data", rx_data, 8'hA3);
    check("xa3_perr", rx_parity_err, 1);
    check("xa3_ferr", rx_frame_err, 0);
    pop_one();
    idle(20);

    // Break: stop bit 0 then line held low
    send_frame(8'h00, 1'b0, 1'b0);
    idle(40 * CLK_DIV);
    check("break_level", fifo_level, 1);
    check("break_ferr", rx_frame_err, 1);
    ser_rx = 1'b1;
    idle(30);
    send_frame(8'h12, 1'b0, 1'b1);
    idle(4);
    check("after_break_level", fifo_level, 2);
    pop_one();
    check("x12_entry", {rx_frame_err, rx_parity_err, rx_data}, {2'b00, 8'h12});
    pop_one();
    idle(20);

    // Short low glitch is a false start
    @(negedge clk);
    ser_rx = 1'b0;
    idle(5);
    ser_rx = 1'b1;
    idle(40);
    check("glitch_level", fifo_level, 0);
    send_frame(8'h81, 1'b0, 1'b1);
    idle(4);
    check("post_glitch_data", rx_data, 8'h81);
    pop_one();
    idle(20);

    // Overrun with consumer stalled
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_frame(d, ^d, 1'b1);
      idle(8);
    end
    check("ovr_level", fifo_level, 4);
    check("ovr_flag", overrun, 1);
    for (int i = 1; i <= 4; i++) begin
      check("ovr_pop_data", rx_data, i);
      pop_one();
    end
    check("ovr_drained", fifo_level, 0);
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("ovr_cleared", overrun, 0);
    idle(20);

    // Reset in the middle of data bit 3
    fork
      send_frame(8'h7E, 1'b0, 1'b1);
      begin
        repeat (1 + CLK_DIV * 4 + CLK_DIV / 2) @(negedge clk);
        resetn = 1'b0;
      end
    join
    idle(2);
    resetn = 1'b1;
    idle(10);
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(4);
    check("rst_level", fifo_level, 1);
    check("rst_data", rx_data, 8'h3C);
    check("rst_overrun", overrun, 0);
    pop_one();
    idle(10);

    // Random frames, random consumer
    rand_mode = 1'b1;
    for (int f = 0; f < 24; f++) begin
      ready_div = (f < 12) ? 2 : 48;
      d  = 8'($urandom);
      pb = (^d) ^ ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 5) != 0);
      send_frame(d, pb, sb);
      if (!sb) idle($urandom_range(0, 40));
      ser_rx = 1'b1;
      idle($urandom_range(4, 30));
    end
    rand_mode = 1'b0;
    @(negedge clk);
    clear_err = 1'b0;
    rx_ready  = 1'b1;
    idle(20);
    rx_ready  = 1'b0;
    check("final_level", fifo_level, 0);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 16: clk cycles per bit, even, >= 4.
REQ-002 The block SHALL have parameter DATA_BITS, default 8: data bits per frame, 5..9.
REQ-003 The block SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4: receive FIFO entries, power of 2, >= 2.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port ser_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-008 The block SHALL have port rx_data, output, DATA_BITS: data of the FIFO head entry.
REQ-009 The block SHALL have port rx_frame_err, output, 1 bit: head entry had stop bit = 0.
REQ-010 The block SHALL have port rx_parity_err, output, 1 bit: head entry had a parity mismatch; always 0 when PARITY = 0.
REQ-011 The block SHALL have port rx_valid, output, 1 bit: FIFO non-empty, head fields valid.
REQ-012 The block SHALL have port rx_ready, input, 1 bit: consumer pops the head when rx_valid && rx_ready.
REQ-013 The block SHALL have port overrun, output, 1 bit: sticky flag, a frame was dropped because the FIFO was full.
REQ-014 The block SHALL have port clear_err, input, 1 bit: clears overrun.
REQ-015 The block SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: number of stored entries.

Function
REQ-016 ser_rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; all references to "rx" below mean the synchronized value.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH, with a bit counter cnt (0..CLK_DIV-1) and a bit index.
REQ-018 IDLE: rx = 0 SHALL cause a transition to START with cnt = 0.
REQ-019 START: at cnt = CLK_DIV/2-1 the FSM SHALL sample rx. rx = 1 is a false start and SHALL return to IDLE with no entry. rx = 0 SHALL go to DATA with cnt = 0 and index = 0.
REQ-020 DATA: each bit SHALL be sampled at cnt = CLK_DIV-1, LSB first. After DATA_BITS samples the FSM SHALL go to PARITY if PARITY != 0, else to STOP.
REQ-021 PARITY: the bit SHALL be sampled at cnt = CLK_DIV-1. Error when XOR(data, parity bit) = 0 for odd, or = 1 for even.
REQ-022 STOP: the bit SHALL be sampled at cnt = CLK_DIV-1, and the push SHALL occur in the same cycle. Stop = 1 goes to IDLE; stop = 0 sets the frame error and goes to WAIT_HIGH.
REQ-023 WAIT_HIGH SHALL remain until rx = 1, then go to IDLE, so that a held-low break yields exactly one entry.
REQ-024 Each push SHALL write {frame_err, parity_err, data} as one FIFO entry.
REQ-025 A push SHALL be accepted if fifo_level < FIFO_DEPTH, or if a pop occurs in the same cycle.
REQ-026 Otherwise the frame SHALL be discarded, FIFO contents left unchanged, and overrun set to 1.
REQ-027 The FIFO SHALL be show-ahead. rx_valid and the head fields SHALL update on the cycle after a push into an empty FIFO, with a 1-cycle push-to-valid latency.
REQ-028 A pop SHALL present the next entry on the following cycle. A simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH. rx_ready while rx_valid = 0 SHALL have no effect.
REQ-030 clear_err SHALL clear overrun on the next cycle. If an overrun occurs in the same cycle as clear_err, overrun SHALL remain 1.
REQ-031 rx_data, rx_frame_err and rx_parity_err SHALL hold their last values while rx_valid = 0.

Reset
REQ-032 While resetn = 0 at a rising edge, the FSM SHALL enter IDLE and cnt, index and the FIFO pointers SHALL be 0.
REQ-033 Reset values SHALL be: rx_valid = 0, fifo_level = 0, overrun = 0, rx_data = 0, rx_frame_err = 0, rx_parity_err = 0, synchronizer = 1.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame. After release, reception SHALL restart only on a new falling edge of rx.

Verification (CLK_DIV = 16, DATA_BITS = 8, PARITY = 2, FIFO_DEPTH = 4)
REQ-035 Send 0x55 with parity 0 and stop 1 -> rx_data = 0x55, both error flags 0, rx_valid within 10.5 bit times + 4 clk of the start edge, fifo_level = 1.
REQ-036 Send 0xA3 with parity 1 (wrong) -> rx_data = 0xA3, rx_parity_err = 1, rx_frame_err = 0.
REQ-037 Send 0x00 with stop 0, then hold ser_rx low for 40 bit times -> exactly one entry with rx_frame_err = 1; the next valid byte 0x12 is received correctly after the line returns high.
REQ-038 Drive a ser_rx low pulse of 5 clk -> no entry, FSM back in IDLE, fifo_level = 0.
REQ-039 With rx_ready = 0, send 0x01..0x05 -> fifo_level = 4, overrun = 1, pops yield 0x01..0x04; pulsing clear_err gives overrun = 0.
REQ-040 Assert resetn = 0 during DATA bit 3 of 0x7E, then send 0x3C -> only 0x3C is received and overrun = 0.
